// File: rtl/pcileech_tlp_tx_arb_pkg.sv
// ----------------------------------------------------------------------------
// pcileech_header
//   Types and constants shared by the TLP transmit arbiter and its round-robin
//   picker.
//   - tx_arb_state_t   : arbiter FSM state encoding
//   - TUSER_DISCONTINUE: tuser bit that tells the PCIe core to discard a TLP
//   - GRANT_W          : width of a source index (up to 8 sources)
// ----------------------------------------------------------------------------
package pcileech_header;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } tx_arb_state_t;

    localparam int TUSER_DISCONTINUE = 3;
    localparam int GRANT_W           = 3;

endpackage

// File: rtl/pcileech_tlp_tx_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// pcileech_rr_pick
//   Combinational round-robin picker. Returns the first requester strictly
//   after i_ptr, wrapping around, so the previous winner has lowest priority.
//   Ports:
//     i_req  : request vector, one bit per source
//     i_ptr  : index of the last winner
//     o_idx  : index of the selected requester (0 when none)
//     o_any  : at least one request is present
// ----------------------------------------------------------------------------
module pcileech_rr_pick
    import pcileech_header::*;
#(
    parameter int NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [GRANT_W-1:0] i_ptr,
    output logic [GRANT_W-1:0] o_idx,
    output logic               o_any
);

    int w_dist;
    int w_best;

    // Distance of source s from the pointer is (s - ptr - 1) mod NUM_SRC;
    // the requester with the smallest distance wins.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_dist = 0;
        w_best = NUM_SRC;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_dist = s - int'(i_ptr) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_SRC;
            end
            if (i_req[s] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = GRANT_W'(s);
                o_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcileech_tlp_tx_arb.sv
// ----------------------------------------------------------------------------
// pcileech_tlp_tx_arb
//   Packet-atomic round-robin arbiter feeding the PCIe core transmit stream
//   from several TLP sources. A granted source keeps the stream until its
//   tlast handshake. A source that stalls mid-packet for STALL_TIMEOUT cycles
//   is cut off with a discontinue beat and the rest of its packet is dropped.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no grant; pick the next requester round-robin
//   LOCK  | granted source passed straight through to the core
//   ABORT | present one tlast beat with tuser discontinue to the core
//   DRAIN | swallow the aborted source's beats up to its tlast
//
//   Ports:
//     clk, rst_n                    : clock, async active-low reset
//     s_tdata/tkeep/tuser/tlast/
//     s_tvalid/s_tready             : packed source streams, source i at slot i
//     m_tdata/tkeep/tuser/tlast/
//     m_tvalid/m_tready             : stream to the PCIe core
//     grant_id                      : current or last granted source
//     pkt_count                     : packets forwarded with a normal tlast
//     err_abort                     : sticky, set on any abort
// ----------------------------------------------------------------------------
module pcileech_tlp_tx_arb
    import pcileech_header::*;
#(
    parameter int          NUM_SRC       = 3,
    parameter int          DATA_W        = 64,
    parameter int          USER_W        = 4,
    parameter logic [15:0] STALL_TIMEOUT = 16'd256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC*DATA_W-1:0]    s_tdata,
    input  logic [NUM_SRC*(DATA_W/8)-1:0] s_tkeep,
    input  logic [NUM_SRC*USER_W-1:0]    s_tuser,
    input  logic [NUM_SRC-1:0]           s_tlast,
    input  logic [NUM_SRC-1:0]           s_tvalid,
    output logic [NUM_SRC-1:0]           s_tready,
    output logic [DATA_W-1:0]            m_tdata,
    output logic [DATA_W/8-1:0]          m_tkeep,
    output logic [USER_W-1:0]            m_tuser,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [2:0]                   grant_id,
    output logic [15:0]                  pkt_count,
    output logic                         err_abort
);

    localparam int KEEP_W = DATA_W / 8;

    tx_arb_state_t        r_state;
    tx_arb_state_t        w_next_state;
    logic [GRANT_W-1:0]   r_rr_ptr;
    logic [GRANT_W-1:0]   r_grant;
    logic [15:0]          r_pkt_count;
    logic                 r_err_abort;
    logic [15:0]          r_stall;

    logic [GRANT_W-1:0]   w_pick_idx;
    logic                 w_pick_any;

    logic [NUM_SRC-1:0]   w_grant_oh;
    logic [DATA_W-1:0]    w_g_tdata;
    logic [KEEP_W-1:0]    w_g_tkeep;
    logic [USER_W-1:0]    w_g_tuser;
    logic                 w_g_tlast;
    logic                 w_g_tvalid;

    logic                 w_lock_enter;
    logic                 w_beat_acc;
    logic                 w_pkt_done;
    logic                 w_abort_start;
    logic                 w_stall_hit;

    pcileech_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .i_req (s_tvalid),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Source mux driven from the registered grant only, so the output path
    // never depends on the picker.
    always_comb begin
        w_grant_oh = '0;
        w_g_tdata  = '0;
        w_g_tkeep  = '0;
        w_g_tuser  = '0;
        w_g_tlast  = 1'b0;
        w_g_tvalid = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (r_grant == GRANT_W'(s)) begin
                w_grant_oh[s] = 1'b1;
                w_g_tdata     = s_tdata[s*DATA_W +: DATA_W];
                w_g_tkeep     = s_tkeep[s*KEEP_W +: KEEP_W];
                w_g_tuser     = s_tuser[s*USER_W +: USER_W];
                w_g_tlast     = s_tlast[s];
                w_g_tvalid    = s_tvalid[s];
            end
        end
    end

    // The abort fires on the STALL_TIMEOUT-th consecutive invalid cycle, so
    // the compare is against the count of cycles already seen (timeout-1).
    // A zero timeout disables the abort path entirely.
    always_comb begin
        w_stall_hit = 1'b0;
        if (STALL_TIMEOUT != 16'd0) begin
            w_stall_hit = !w_g_tvalid && (r_stall >= (STALL_TIMEOUT - 16'd1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        s_tready      = '0;
        m_tdata       = '0;
        m_tkeep       = '0;
        m_tuser       = '0;
        m_tlast       = 1'b0;
        m_tvalid      = 1'b0;
        w_lock_enter  = 1'b0;
        w_beat_acc    = 1'b0;
        w_pkt_done    = 1'b0;
        w_abort_start = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_lock_enter = 1'b1;
                    w_next_state = ST_LOCK;
                end
            end

            ST_LOCK: begin
                m_tdata  = w_g_tdata;
                m_tkeep  = w_g_tkeep;
                m_tuser  = w_g_tuser;
                m_tlast  = w_g_tlast;
                m_tvalid = w_g_tvalid;
                s_tready = w_grant_oh & {NUM_SRC{m_tready}};
                if (w_g_tvalid && m_tready) begin
                    w_beat_acc = 1'b1;
                    if (w_g_tlast) begin
                        w_pkt_done   = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end else if (w_stall_hit) begin
                    w_abort_start = 1'b1;
                    w_next_state  = ST_ABORT;
                end
            end

            ST_ABORT: begin
                m_tvalid                   = 1'b1;
                m_tlast                    = 1'b1;
                m_tkeep                    = '1;
                m_tuser[TUSER_DISCONTINUE] = 1'b1;
                if (m_tready) begin
                    w_next_state = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                s_tready = w_grant_oh;
                if (w_g_tvalid && w_g_tlast) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= GRANT_W'(NUM_SRC - 1);
            r_grant     <= '0;
            r_pkt_count <= '0;
            r_err_abort <= 1'b0;
            r_stall     <= '0;
        end else begin
            if (w_lock_enter) begin
                r_grant  <= w_pick_idx;
                r_rr_ptr <= w_pick_idx;
            end
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
            if (w_abort_start) begin
                r_err_abort <= 1'b1;
            end
            // Saturate so a disabled timeout never wraps back into range.
            if (w_lock_enter || w_beat_acc) begin
                r_stall <= '0;
            end else if ((r_state == ST_LOCK) && !w_g_tvalid && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign grant_id  = r_grant;
    assign pkt_count = r_pkt_count;
    assign err_abort = r_err_abort;

endmodule
